// File: rtl/mpt_pkg.sv
// rtl/mpt_pkg.sv - shared MPT walker transaction/response types and encodings
package mpt_pkg;

    localparam int TRANSACTION_FIFO_DEPTH = 16;
    localparam int MPT_ID_W               = $clog2(TRANSACTION_FIFO_DEPTH);

    localparam logic [2:0] ACC_R = 3'b001;
    localparam logic [2:0] ACC_W = 3'b010;
    localparam logic [2:0] ACC_X = 3'b100;

    typedef enum logic [1:0] {
        FAULT_NONE = 2'd0,
        FAULT_PERM = 2'd1,
        FAULT_WALK = 2'd2
    } fault_cause_e;

    typedef struct packed {
        logic [MPT_ID_W-1:0] id;
        logic [2:0]          access_type;
        logic [2:0]          perm;
        logic                fault;
    } mptw_transaction_t;

    typedef struct packed {
        logic [MPT_ID_W-1:0] id;
        logic                grant;
        fault_cause_e        fault_cause;
    } mptw_response_t;

    // Every requested R/W/X bit must be present in the permission field.
    function automatic logic perm_covers(input logic [2:0] perm, input logic [2:0] access_type);
        return (perm & access_type) == access_type;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that holds at all-ones
module sat_counter #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/commit_stage.sv
// rtl/commit_stage.sv - evaluates retired walker transactions and returns permission responses
`ifndef MPT_PIPE_MACROS
`define MPT_PIPE_MACROS
`define MPT_PIPE_SLAVE(v, r, d, w) input logic v, output logic r, input logic [(w)-1:0] d
`define MPT_PIPE_MASTER(v, r, d, w) output logic v, input logic r, output logic [(w)-1:0] d
`endif

module commit_stage
    import mpt_pkg::*;
#(
    parameter int          PIPELINE_SLAVE_DATA_WIDTH  = $bits(mptw_transaction_t),
    parameter int          PIPELINE_MASTER_DATA_WIDTH = $bits(mptw_response_t),
    parameter int          ID_WIDTH                   = $clog2(TRANSACTION_FIFO_DEPTH),
    parameter logic [15:0] GRANTED_CNT_INIT           = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    `MPT_PIPE_SLAVE(retire_stage_slave_valid_i, retire_stage_slave_ready_o,
                    retire_stage_slave_data_i, PIPELINE_SLAVE_DATA_WIDTH),
    `MPT_PIPE_MASTER(response_master_valid_o, response_master_ready_i,
                     response_master_data_o, PIPELINE_MASTER_DATA_WIDTH),
    output logic [15:0] granted_cnt_o,
    output logic [15:0] denied_cnt_o,
    output logic        order_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } commit_fsm_e;

    commit_fsm_e         state_q, state_d;
    mptw_transaction_t   txn_q, txn_d;
    mptw_response_t      resp_q, resp_d;
    logic [ID_WIDTH-1:0] expected_id_q, expected_id_d;
    logic                order_err_q, order_err_d;

    mptw_transaction_t   txn_in;
    logic                grant;
    logic                master_fire;

    assign txn_in = mptw_transaction_t'(retire_stage_slave_data_i[$bits(mptw_transaction_t)-1:0]);

    always_comb begin
        state_d                    = state_q;
        txn_d                      = txn_q;
        resp_d                     = resp_q;
        expected_id_d              = expected_id_q;
        order_err_d                = order_err_q;
        grant                      = 1'b0;
        retire_stage_slave_ready_o = 1'b0;
        response_master_valid_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                retire_stage_slave_ready_o = rst_ni;
                if (retire_stage_slave_valid_i && rst_ni) begin
                    txn_d = txn_in;
                    // A gap or repeat is flagged but the stream resyncs to the received id.
                    if (ID_WIDTH'(txn_in.id) != expected_id_q) begin
                        order_err_d = 1'b1;
                    end
                    expected_id_d = ID_WIDTH'(txn_in.id) + ID_WIDTH'(1);
                    state_d       = EVAL;
                end
            end
            EVAL: begin
                grant        = !txn_q.fault && perm_covers(txn_q.perm, txn_q.access_type);
                resp_d.id    = txn_q.id;
                resp_d.grant = grant;
                if (txn_q.fault) begin
                    resp_d.fault_cause = FAULT_WALK;
                end else if (!grant) begin
                    resp_d.fault_cause = FAULT_PERM;
                end else begin
                    resp_d.fault_cause = FAULT_NONE;
                end
                state_d = RESP;
            end
            RESP: begin
                response_master_valid_o = 1'b1;
                if (response_master_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            txn_q         <= '0;
            resp_q        <= '0;
            expected_id_q <= '0;
            order_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            txn_q         <= txn_d;
            resp_q        <= resp_d;
            expected_id_q <= expected_id_d;
            order_err_q   <= order_err_d;
        end
    end

    assign master_fire            = response_master_valid_o && response_master_ready_i;
    assign response_master_data_o = PIPELINE_MASTER_DATA_WIDTH'(resp_q);
    assign order_err_o            = order_err_q;

    sat_counter #(
        .WIDTH      (16),
        .RESET_VALUE(GRANTED_CNT_INIT)
    ) u_granted_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (master_fire && resp_q.grant),
        .count_o(granted_cnt_o)
    );

    sat_counter #(
        .WIDTH      (16),
        .RESET_VALUE(16'h0000)
    ) u_denied_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (master_fire && !resp_q.grant),
        .count_o(denied_cnt_o)
    );

endmodule

// File: tb/tb_commit_stage.sv
// tb/tb_commit_stage.sv - directed self-checking bench for commit_stage
module tb_commit_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [10:0] data_i;
    logic        ready_i;

    logic        ready_o,   sat_ready_o;
    logic        valid_o,   sat_valid_o;
    logic [6:0]  data_o,    sat_data_o;
    logic [15:0] g_cnt,     sat_g_cnt;
    logic [15:0] d_cnt,     sat_d_cnt;
    logic        order_err, sat_order_err;

    int n_cmp = 0;
    int n_err = 0;

    commit_stage dut (
        .clk_i                     (clk),
        .rst_ni                    (rst_n),
        .retire_stage_slave_valid_i(valid_i),
        .retire_stage_slave_ready_o(ready_o),
        .retire_stage_slave_data_i (data_i),
        .response_master_valid_o   (valid_o),
        .response_master_ready_i   (ready_i),
        .response_master_data_o    (data_o),
        .granted_cnt_o             (g_cnt),
        .denied_cnt_o              (d_cnt),
        .order_err_o               (order_err)
    );

    commit_stage #(.GRANTED_CNT_INIT(16'hFFFE)) dut_sat (
        .clk_i                     (clk),
        .rst_ni                    (rst_n),
        .retire_stage_slave_valid_i(valid_i),
        .retire_stage_slave_ready_o(sat_ready_o),
        .retire_stage_slave_data_i (data_i),
        .response_master_valid_o   (sat_valid_o),
        .response_master_ready_i   (ready_i),
        .response_master_data_o    (sat_data_o),
        .granted_cnt_o             (sat_g_cnt),
        .denied_cnt_o              (sat_d_cnt),
        .order_err_o               (sat_order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one transaction from a negedge and follows it through EVAL and RESP.
    task automatic run_txn(input logic [3:0] id, input logic [2:0] acc, input logic [2:0] perm,
                           input logic flt, input logic [6:0] exp_resp, input int stall,
                           input logic exp_err_pre, input logic exp_err_post,
                           input logic [15:0] exp_g, input logic [15:0] exp_d,
                           input logic [15:0] exp_sat_g);
        logic [15:0] pre_g;
        logic [15:0] pre_d;
        pre_g   = exp_g - {15'b0, exp_resp[2]};
        pre_d   = exp_d - {15'b0, !exp_resp[2]};
        valid_i = 1'b1;
        data_i  = {id, acc, perm, flt};
        ready_i = (stall == 0);
        check("idle_ready", ready_o, 1);
        check("pre_order_err", order_err, exp_err_pre);
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = '0;
        check("eval_valid", valid_o, 0);
        check("eval_ready", ready_o, 0);
        check("post_order_err", order_err, exp_err_post);
        @(negedge clk);
        check("resp_valid", valid_o, 1);
        check("resp_data", data_o, exp_resp);
        check("resp_sat_data", sat_data_o, exp_resp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", valid_o, 1);
            check("stall_data", data_o, exp_resp);
            check("stall_ready", ready_o, 0);
            check("stall_granted", g_cnt, pre_g);
            check("stall_denied", d_cnt, pre_d);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("done_valid", valid_o, 0);
        check("done_ready", ready_o, 1);
        check("granted_cnt", g_cnt, exp_g);
        check("denied_cnt", d_cnt, exp_d);
        check("sat_granted_cnt", sat_g_cnt, exp_sat_g);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("init_ready", ready_o, 1);
        check("init_granted", g_cnt, 0);
        check("init_denied", d_cnt, 0);
        check("init_order_err", order_err, 0);
        check("init_sat_granted", sat_g_cnt, 16'hFFFE);

        // grant, permission denial, walk fault, then a stalled grant
        run_txn(4'd0, 3'b001, 3'b011, 1'b0, 7'h04, 0,  1'b0, 1'b0, 16'd1, 16'd0, 16'hFFFF);
        run_txn(4'd1, 3'b010, 3'b001, 1'b0, 7'h09, 0,  1'b0, 1'b0, 16'd1, 16'd1, 16'hFFFF);
        run_txn(4'd2, 3'b100, 3'b111, 1'b1, 7'h12, 0,  1'b0, 1'b0, 16'd1, 16'd2, 16'hFFFF);
        run_txn(4'd3, 3'b100, 3'b100, 1'b0, 7'h1C, 10, 1'b0, 1'b0, 16'd2, 16'd2, 16'hFFFF);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_granted", g_cnt, 0);
        check("rst2_denied", d_cnt, 0);
        check("rst2_sat_granted", sat_g_cnt, 16'hFFFE);

        // out-of-order id 3 after 0,1; saturating grant count on dut_sat
        run_txn(4'd0, 3'b001, 3'b001, 1'b0, 7'h04, 0, 1'b0, 1'b0, 16'd1, 16'd0, 16'hFFFF);
        run_txn(4'd1, 3'b001, 3'b001, 1'b0, 7'h0C, 0, 1'b0, 1'b0, 16'd2, 16'd0, 16'hFFFF);
        run_txn(4'd3, 3'b001, 3'b001, 1'b0, 7'h1C, 0, 1'b0, 1'b1, 16'd3, 16'd0, 16'hFFFF);
        run_txn(4'd4, 3'b001, 3'b001, 1'b0, 7'h24, 0, 1'b1, 1'b1, 16'd4, 16'd0, 16'hFFFF);

        // reset while a response is pending
        valid_i = 1'b1;
        data_i  = {4'd5, 3'b001, 3'b001, 1'b0};
        ready_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = '0;
        @(negedge clk);
        check("abort_resp_valid", valid_o, 1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", valid_o, 0);
        check("abort_sat_valid", sat_valid_o, 0);
        check("abort_data", data_o, 0);
        check("abort_ready", ready_o, 0);
        check("abort_order_err", order_err, 0);
        check("abort_granted", g_cnt, 0);
        check("abort_sat_granted", sat_g_cnt, 16'hFFFE);
        @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_abort_valid", valid_o, 0);
            check("post_abort_ready", ready_o, 1);
        end
        check("post_abort_granted", g_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
